// File: rtl/vga_pkg.sv
// Shared constants and types for the character-cell VGA read path.
package vga_pkg;

    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;
    localparam int CHAR_W   = 9;
    localparam int CHAR_H   = 16;
    localparam int COLS     = 70;
    localparam int ROWS     = 30;

    typedef logic [11:0] rgb12_t;

    typedef struct packed {
        logic       hl;
        logic [7:0] code;
    } cell_t;

endpackage

// File: rtl/font_rom_9x16.sv
// 2048x9 glyph ROM addressed by {code[6:0], line[3:0]}, one-cycle registered read.
// Glyph rows are held in a case table, so no external image file is needed.
module font_rom_9x16 (
    input  logic        clk,
    input  logic [10:0] i_addr,
    output logic [8:0]  o_row
);

    function automatic logic [8:0] glyph_row(input logic [6:0] code, input logic [3:0] line);
        glyph_row = 9'h000;
        case (code)
            7'h41: begin
                case (line)
                    4'd1:                                       glyph_row = 9'h010;
                    4'd2:                                       glyph_row = 9'h038;
                    4'd3:                                       glyph_row = 9'h06C;
                    4'd4, 4'd5, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11: glyph_row = 9'h0C6;
                    4'd6:                                       glyph_row = 9'h0FE;
                    default:                                    glyph_row = 9'h000;
                endcase
            end
            7'h7F:   glyph_row = 9'h1FF;
            default: glyph_row = 9'h000;
        endcase
    endfunction

    // NOTE: ROM contents and its output register carry no reset; the pipeline
    // valid flags downstream decide whether the row is ever shown.
    always_ff @(posedge clk) begin
        o_row <= glyph_row(i_addr[10:4], i_addr[3:0]);
    end

endmodule

// File: rtl/vga_char_reader.sv
// Character-cell VGA reader: scan position -> RAM cell address -> glyph -> 12-bit pixel, 4-clock latency.
// Optional cursor blink (adds cursor_pos port) is enabled with `define VGA_CURSOR_BLINK_EN.
module vga_char_reader #(
    parameter int              RAM_WIDTH = 8,
    parameter int              COLS      = vga_pkg::COLS,
    parameter int              ROWS      = vga_pkg::ROWS,
    parameter vga_pkg::rgb12_t FG_COLOR  = 12'hFFF,
    parameter vga_pkg::rgb12_t HL_COLOR  = 12'hF80,
    parameter vga_pkg::rgb12_t BG_COLOR  = 12'h000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [9:0]           h_addr,
    input  logic [8:0]           v_addr,
    input  logic                 valid,
    input  logic                 hsync_in,
    input  logic                 vsync_in,
    output logic [11:0]          ram_pos,
    input  logic [RAM_WIDTH:0]   ram_data,
    output logic [11:0]          vga_rgb,
    output logic                 hsync_out,
    output logic                 vsync_out
`ifdef VGA_CURSOR_BLINK_EN
    ,
    input  logic [11:0]          cursor_pos
`endif
);
    import vga_pkg::*;

    localparam logic [3:0] XSUB_LAST = 4'(CHAR_W - 1);
    localparam logic [6:0] COLS_L    = 7'(COLS);
    localparam logic [4:0] ROWS_L    = 5'(ROWS);

    logic [3:0]  r_x_cnt, w_x_cur;
    logic [6:0]  r_col_cnt, w_col_cur;
    logic [4:0]  w_row;
    logic [11:0] w_pos;

    // NOTE: every always_comb output is given a default first so no latch is inferred.
    always_comb begin
        w_x_cur   = r_x_cnt;
        w_col_cur = r_col_cnt;
        if (valid && h_addr == 10'd0) begin
            w_x_cur   = '0;
            w_col_cur = '0;
        end
    end

    // row*70 as row*64 + row*4 + row*2, kept at 12 bits.
    assign w_row = v_addr[8:4];
    assign w_pos = {1'b0, w_row, 6'b0} + {5'b0, w_row, 2'b0} + {6'b0, w_row, 1'b0} + {5'b0, w_col_cur};

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_x_cnt   <= '0;
            r_col_cnt <= '0;
        end else if (valid) begin
            if (w_x_cur == XSUB_LAST) begin
                r_x_cnt   <= '0;
                r_col_cnt <= w_col_cur + 7'd1;
            end else begin
                r_x_cnt   <= w_x_cur + 4'd1;
                r_col_cnt <= w_col_cur;
            end
        end
    end

    logic        r1_valid, r1_in_grid, r2_valid, r2_in_grid, r2_cursor, r3_valid, r3_show, r3_hl, r3_cursor;
    logic [11:0] r1_pos;
    logic [3:0]  r1_xsub, r1_line, r2_xsub, r2_line, r3_xsub;
    logic [3:4-4] r_unused_pad;
    logic        w_code_ok, w_cursor_hit, w_bit;
    logic [8:0]  w_glyph;
    logic [3:0]  r_hs_sr, r_vs_sr;
    rgb12_t      r4_rgb, w_rgb;

    // The RAM's own read register forms S2 for the code; side data is delayed beside it.
    assign w_code_ok = (ram_data[RAM_WIDTH-1:7] == '0) && (ram_data[6:0] != 7'd0);

`ifdef VGA_CURSOR_BLINK_EN
    logic        r_vs_prev;
    logic [23:0] r_frame_cnt;
    logic        w_unused_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vs_prev   <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            r_vs_prev <= vsync_in;
            if (vsync_in && !r_vs_prev) r_frame_cnt <= r_frame_cnt + 24'd1;
        end
    end

    assign w_unused_cnt = ^{r_frame_cnt[23:5], r_frame_cnt[3:0]};
    assign w_cursor_hit = r_frame_cnt[4] && r1_in_grid && (r1_pos == cursor_pos);
`else
    assign w_cursor_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r1_valid <= 1'b0; r1_in_grid <= 1'b0; r1_pos <= '0; r1_xsub <= '0; r1_line <= '0;
            r2_valid <= 1'b0; r2_in_grid <= 1'b0; r2_cursor <= 1'b0; r2_xsub <= '0; r2_line <= '0;
            r3_valid <= 1'b0; r3_show <= 1'b0; r3_hl <= 1'b0; r3_cursor <= 1'b0; r3_xsub <= '0;
            r4_rgb   <= '0;
            r_hs_sr  <= '0;
            r_vs_sr  <= '0;
            r_unused_pad <= '0;
        end else begin
            r1_valid   <= valid;
            r1_in_grid <= valid && (w_col_cur < COLS_L) && (w_row < ROWS_L);
            r1_pos     <= w_pos;
            r1_xsub    <= w_x_cur;
            r1_line    <= v_addr[3:0];

            r2_valid   <= r1_valid;
            r2_in_grid <= r1_in_grid;
            r2_cursor  <= w_cursor_hit;
            r2_xsub    <= r1_xsub;
            r2_line    <= r1_line;

            r3_valid   <= r2_valid;
            r3_show    <= r2_in_grid && w_code_ok;
            r3_hl      <= ram_data[RAM_WIDTH];
            r3_cursor  <= r2_cursor;
            r3_xsub    <= r2_xsub;

            r4_rgb     <= w_rgb;
            r_hs_sr    <= {r_hs_sr[2:0], hsync_in};
            r_vs_sr    <= {r_vs_sr[2:0], vsync_in};
            r_unused_pad <= '0;
        end
    end

    font_rom_9x16 u_font (
        .clk    (clk),
        .i_addr ({ram_data[6:0], r2_line}),
        .o_row  (w_glyph)
    );

    // Leftmost pixel of a cell is glyph bit 8; the cursor cell swaps fg and bg.
    always_comb begin
        w_bit = r3_show && w_glyph[XSUB_LAST - r3_xsub];
        w_rgb = BG_COLOR;
        if (!r3_valid)      w_rgb = '0;
        else if (r3_cursor) w_rgb = w_bit ? BG_COLOR : FG_COLOR;
        else if (w_bit)     w_rgb = r3_hl ? HL_COLOR : FG_COLOR;
    end

    assign ram_pos   = r1_pos;
    assign vga_rgb   = r4_rgb;
    assign hsync_out = r_hs_sr[3];
    assign vsync_out = r_vs_sr[3];

endmodule

// File: tb/tb_vga_char_reader.sv
// Scoreboard bench for vga_char_reader: directed scan lines against a registered-read RAM model.
module tb_vga_char_reader;
    import vga_pkg::*;

    localparam int K_RGB = 0;
    localparam int K_POS = 1;
    localparam int K_HS  = 2;
    localparam int K_VS  = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  h_addr = '0;
    logic [8:0]  v_addr = '0;
    logic        valid = 1'b0, hsync_in = 1'b0, vsync_in = 1'b0;
    logic [11:0] ram_pos;
    logic [8:0]  ram_data = '0;
    logic [11:0] vga_rgb;
    logic        hsync_out, vsync_out;
`ifdef VGA_CURSOR_BLINK_EN
    logic [11:0] cursor_pos = '0;
`endif

    always #20 clk = ~clk;

    vga_char_reader dut (
        .clk       (clk),
        .rst       (rst),
        .h_addr    (h_addr),
        .v_addr    (v_addr),
        .valid     (valid),
        .hsync_in  (hsync_in),
        .vsync_in  (vsync_in),
        .ram_pos   (ram_pos),
        .ram_data  (ram_data),
        .vga_rgb   (vga_rgb),
        .hsync_out (hsync_out),
        .vsync_out (vsync_out)
`ifdef VGA_CURSOR_BLINK_EN
        ,
        .cursor_pos(cursor_pos)
`endif
    );

    logic [8:0] ram [0:4095];
    always @(posedge clk) ram_data <= ram[ram_pos];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int due; int kind; logic [11:0] val; int v; int h; } exp_t;
    typedef struct { int h; int kind; int off; logic [11:0] val; } req_t;
    exp_t sb[$];
    req_t reqs[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cur_v = 0;

    function automatic string kname(input int k);
        case (k)
            K_RGB:   return "vga_rgb";
            K_POS:   return "ram_pos";
            K_HS:    return "hsync_out";
            default: return "vsync_out";
        endcase
    endfunction

    function automatic logic [8:0] mk(input logic hl, input logic [7:0] code);
        cell_t c;
        c.hl   = hl;
        c.code = code;
        return c;
    endfunction

    task automatic check(input string what, input logic [11:0] act, input logic [11:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", what, act, exp);
        end
    endtask

    // Monitor: compares every scoreboard entry that falls due this cycle.
    always @(negedge clk) begin
        logic [11:0] act;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due == cyc) begin
                case (sb[i].kind)
                    K_RGB:   act = vga_rgb;
                    K_POS:   act = ram_pos;
                    K_HS:    act = {11'b0, hsync_out};
                    default: act = {11'b0, vsync_out};
                endcase
                n_cmp++;
                if (act !== sb[i].val) begin
                    n_bad++;
                    $display("FAIL %s v=%0d h=%0d: got %h expected %h",
                             kname(sb[i].kind), sb[i].v, sb[i].h, act, sb[i].val);
                end
                sb.delete(i);
            end
        end
    end

    task automatic push_exp(input int off, input int kind, input logic [11:0] val, input int h);
        exp_t e;
        e.due = cyc + off; e.kind = kind; e.val = val; e.v = cur_v; e.h = h;
        sb.push_back(e);
    endtask

    task automatic want(input int h, input int kind, input int off, input logic [11:0] val);
        req_t r;
        r.h = h; r.kind = kind; r.off = off; r.val = val;
        reqs.push_back(r);
    endtask

    task automatic drive(input int h, input int v, input logic val, input logic hs,
                         input logic vs, input logic r);
        @(posedge clk);
        #1;
        h_addr   = 10'(h);
        v_addr   = 9'(v);
        valid    = val;
        hsync_in = hs;
        vsync_in = vs;
        rst      = r;
    endtask

    // One line: 640 active pixels then 20 blanking cycles; ranges are inclusive, -1 disables.
    task automatic scan_line(input int v, input int rlo, input int rhi, input int hlo,
                             input int hhi, input int vlo, input int vhi);
        cur_v = v;
        for (int h = 0; h < 660; h++) begin
            drive(h, v, h < 640, h >= hlo && h <= hhi, h >= vlo && h <= vhi, h >= rlo && h <= rhi);
            foreach (reqs[i]) if (reqs[i].h == h) push_exp(reqs[i].off, reqs[i].kind, reqs[i].val, h);
        end
        reqs.delete();
    endtask

    task automatic pulse_vsync(input int n);
        for (int i = 0; i < n; i++) begin
            drive(640, 0, 1'b0, 1'b0, 1'b1, 1'b0);
            drive(640, 0, 1'b0, 1'b0, 1'b1, 1'b0);
            drive(640, 0, 1'b0, 1'b0, 1'b0, 1'b0);
            drive(640, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        #(40 * 100000);
        $display("FAIL watchdog: run exceeded its cycle budget");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4096; i++) ram[i] = 9'h000;

        // Reset state while inputs toggle.
        repeat (4) drive(5, 3, 1'b1, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        check("reset vga_rgb",   vga_rgb,               12'h000);
        check("reset ram_pos",   ram_pos,               12'h000);
        check("reset hsync_out", {11'b0, hsync_out},    12'h000);
        check("reset vsync_out", {11'b0, vsync_out},    12'h000);
        push_exp(1, K_RGB, 12'h000, -1);
        push_exp(1, K_POS, 12'h000, -1);
        push_exp(1, K_HS,  12'h000, -1);
        push_exp(1, K_VS,  12'h000, -1);
        drive(5, 3, 1'b1, 1'b1, 1'b1, 1'b1);
        repeat (2) drive(0, 0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Blank RAM: black everywhere, address of col 20 row 0, hsync delayed by 4.
        want(0,   K_RGB, 4, 12'h000);
        want(180, K_POS, 1, 12'd20);
        want(180, K_RGB, 4, 12'h000);
        want(639, K_RGB, 4, 12'h000);
        want(643, K_HS,  4, 12'h000);
        want(644, K_HS,  4, 12'h001);
        want(649, K_HS,  4, 12'h001);
        want(650, K_HS,  4, 12'h000);
        want(650, K_RGB, 4, 12'h000);
        scan_line(0, -1, -1, 644, 649, -1, -1);

        // 'A' at cell 20, glyph line 6 = 0_1111_1110.
        ram[20] = mk(1'b0, 8'h41);
        want(179, K_RGB, 4, 12'h000);
        want(180, K_RGB, 4, 12'h000);
        want(181, K_RGB, 4, 12'hFFF);
        want(184, K_RGB, 4, 12'hFFF);
        want(187, K_RGB, 4, 12'hFFF);
        want(188, K_RGB, 4, 12'h000);
        want(189, K_RGB, 4, 12'h000);
        scan_line(6, -1, -1, 644, 649, -1, -1);

        // Glyph line 3 = 0_0110_1100.
        want(182, K_RGB, 4, 12'hFFF);
        want(184, K_RGB, 4, 12'h000);
        want(185, K_RGB, 4, 12'hFFF);
        want(187, K_RGB, 4, 12'h000);
        scan_line(3, -1, -1, 644, 649, -1, -1);

        // Highlighted 'A'.
        ram[20] = mk(1'b1, 8'h41);
        want(180, K_RGB, 4, 12'h000);
        want(181, K_RGB, 4, 12'hF80);
        want(187, K_RGB, 4, 12'hF80);
        want(188, K_RGB, 4, 12'h000);
        scan_line(6, -1, -1, 644, 649, -1, -1);

        // Code >= 0x80 renders background even though its low bits index 'A'.
        ram[20] = mk(1'b0, 8'hC1);
        want(181, K_RGB, 4, 12'h000);
        want(184, K_RGB, 4, 12'h000);
        scan_line(6, -1, -1, 644, 649, -1, -1);

        // Last row, last column, and the right margin with nonzero RAM.
        ram[2099] = mk(1'b0, 8'h7F);
        ram[2100] = mk(1'b0, 8'h7F);
        ram[2101] = mk(1'b0, 8'h7F);
        want(620, K_RGB, 4, 12'h000);
        want(621, K_POS, 1, 12'd2099);
        want(621, K_RGB, 4, 12'hFFF);
        want(629, K_RGB, 4, 12'hFFF);
        want(630, K_RGB, 4, 12'h000);
        want(635, K_POS, 1, 12'd2100);
        want(635, K_RGB, 4, 12'h000);
        want(639, K_RGB, 4, 12'h000);
        want(645, K_VS,  4, 12'h000);
        want(646, K_VS,  4, 12'h001);
        want(651, K_VS,  4, 12'h001);
        want(652, K_VS,  4, 12'h000);
        scan_line(479, -1, -1, 644, 649, 646, 651);

        // Reset at pixel 300 of line 100; counters restart at cell 420 after release.
        for (int c = 450; c <= 455; c++) ram[c] = mk(1'b0, 8'h7F);
        ram[420] = mk(1'b0, 8'h7F);
        want(290, K_RGB, 4, 12'hFFF);
        want(300, K_RGB, 1, 12'h000);
        want(300, K_RGB, 2, 12'h000);
        want(300, K_HS,  1, 12'h000);
        want(300, K_HS,  2, 12'h000);
        want(302, K_HS,  4, 12'h000);
        want(303, K_POS, 1, 12'd420);
        want(303, K_RGB, 3, 12'h000);
        want(303, K_RGB, 4, 12'hFFF);
        scan_line(100, 300, 302, 296, 302, -1, -1);

`ifdef VGA_CURSOR_BLINK_EN
        // Cursor on blank cell 90 (row 1, col 20): solid during blink-on, background otherwise.
        drive(640, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        drive(640, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        cursor_pos = 12'd90;
        pulse_vsync(15);
        want(184, K_RGB, 4, 12'h000);
        scan_line(16, -1, -1, 644, 649, -1, -1);
        pulse_vsync(1);
        want(179, K_RGB, 4, 12'h000);
        want(180, K_RGB, 4, 12'hFFF);
        want(184, K_RGB, 4, 12'hFFF);
        want(188, K_RGB, 4, 12'hFFF);
        want(189, K_RGB, 4, 12'h000);
        scan_line(16, -1, -1, 644, 649, -1, -1);
        pulse_vsync(16);
        want(180, K_RGB, 4, 12'h000);
        want(184, K_RGB, 4, 12'h000);
        scan_line(16, -1, -1, 644, 649, -1, -1);
`endif

        repeat (8) drive(640, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        foreach (sb[i]) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s v=%0d h=%0d: never compared, expected %h",
                     kname(sb[i].kind), sb[i].v, sb[i].h, sb[i].val);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
